// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI master register port between two requesters,
// running one TXDATA write / STATUS poll / RXDATA read sequence per accepted byte.
// Optional slave-select mask write per transaction: define SPI_ARB_SSMASK_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | arbitrate, accept one request, latch its byte
// SSMASK   | write slave-select mask of the granted requester (optional)
// POLL_T   | phase 0: read STATUS; phase 1: test TRDY, retry or move on
// WR_TX    | write latched byte to TXDATA
// POLL_R   | phase 0: read STATUS; phase 1: test RRDY, retry or move on
// RD_RX    | phase 0: read RXDATA; phase 1: capture the returned byte
// RESP     | hand the byte (or timeout error) back to the owner
module spi_txn_arbiter #(
   parameter int          DW          = 8,
   parameter logic [2:0]  ADDR_RXDATA = 3'd0,
   parameter logic [2:0]  ADDR_TXDATA = 3'd1,
   parameter logic [2:0]  ADDR_STATUS = 3'd2,
   parameter logic [2:0]  ADDR_SSMASK = 3'd4,
   parameter int          RRDY_BIT    = 7,
   parameter int          TRDY_BIT    = 6,
   parameter logic [15:0] TIMEOUT     = 16'd4095
`ifdef SPI_ARB_SSMASK_EN
   ,parameter logic [DW-1:0] SS0_MASK = 8'h01,
   parameter logic [DW-1:0] SS1_MASK  = 8'h02
`endif
) (
   input  logic          I_CLK,
   input  logic          I_RESETN,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_data,
   output logic          rsp0_err,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_data,
   output logic          rsp1_err,
   output logic          O_TX_EN,
   output logic [2:0]    O_WADDR,
   output logic [DW-1:0] O_WDATA,
   output logic          O_RX_EN,
   output logic [2:0]    O_RADDR,
   input  logic [DW-1:0] I_RDATA,
   output logic          busy,
   output logic [1:0]    grant
);

`ifdef SPI_ARB_SSMASK_EN
   typedef enum logic [2:0] {S_IDLE, S_SSMASK, S_POLL_T, S_WR_TX, S_POLL_R, S_RD_RX, S_RESP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_POLL_T, S_WR_TX, S_POLL_R, S_RD_RX, S_RESP} state_t;
`endif

   state_t        state_q, state_d;
   logic          phase_q, phase_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [DW-1:0] data_q, data_d;
   logic [DW-1:0] rx_q, rx_d;
   logic          err_q, err_d;
   logic [1:0]    grant_q, grant_d;
   logic          rr_last_q, rr_last_d;
   logic          ready_en_q;
   logic          accept_ok, pick0, bit_ok;
   logic          tx_en_q, tx_en_d, rx_en_q, rx_en_d;
   logic [2:0]    waddr_q, waddr_d, raddr_q, raddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic          rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
   logic [DW-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

   // Accept is held off during the response pulse so accept and response never overlap.
   assign accept_ok = ready_en_q && !rsp0_valid_q && !rsp1_valid_q && (state_q == S_IDLE);
   assign pick0     = req0_valid && (!req1_valid || rr_last_q);
   assign bit_ok    = (state_q == S_POLL_T) ? I_RDATA[TRDY_BIT] : I_RDATA[RRDY_BIT];

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      rx_d       = rx_q;
      err_d      = err_q;
      grant_d    = grant_q;
      rr_last_d  = rr_last_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_ok && (req0_valid || req1_valid)) begin
               req0_ready = pick0;
               req1_ready = !pick0;
               data_d     = pick0 ? req0_data : req1_data;
               grant_d    = pick0 ? 2'b01 : 2'b10;
               rr_last_d  = !pick0;
               err_d      = 1'b0;
               phase_d    = 1'b0;
               cnt_d      = '0;
`ifdef SPI_ARB_SSMASK_EN
               state_d    = S_SSMASK;
`else
               state_d    = S_POLL_T;
`endif
            end
         end
`ifdef SPI_ARB_SSMASK_EN
         S_SSMASK: begin
            state_d = S_POLL_T;
            phase_d = 1'b0;
            cnt_d   = '0;
         end
`endif
         S_POLL_T, S_POLL_R: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               cnt_d   = cnt_q + 16'd1;
               if (bit_ok) begin
                  state_d = (state_q == S_POLL_T) ? S_WR_TX : S_RD_RX;
               end else if (cnt_d == TIMEOUT) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  rx_d    = '0;
               end
            end
         end
         S_WR_TX: begin
            state_d = S_POLL_R;
            phase_d = 1'b0;
            cnt_d   = '0;
         end
         S_RD_RX: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               rx_d    = I_RDATA;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
         end
      endcase

      // Port strobes are registered from the next state so they align with the state itself.
      tx_en_d = (state_d == S_WR_TX);
      rx_en_d = !phase_d && ((state_d == S_POLL_T) || (state_d == S_POLL_R) || (state_d == S_RD_RX));
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      raddr_d = raddr_q;
      if (state_d == S_WR_TX) begin
         waddr_d = ADDR_TXDATA;
         wdata_d = data_d;
      end
`ifdef SPI_ARB_SSMASK_EN
      if (state_d == S_SSMASK) begin
         tx_en_d = 1'b1;
         waddr_d = ADDR_SSMASK;
         wdata_d = grant_d[1] ? SS1_MASK : SS0_MASK;
      end
`endif
      if (rx_en_d)
         raddr_d = (state_d == S_RD_RX) ? ADDR_RXDATA : ADDR_STATUS;

      rsp0_valid_d = (state_q == S_RESP) && grant_q[0];
      rsp1_valid_d = (state_q == S_RESP) && grant_q[1];
      rsp0_data_d  = rsp0_valid_d ? rx_q  : rsp0_data_q;
      rsp0_err_d   = rsp0_valid_d ? err_q : rsp0_err_q;
      rsp1_data_d  = rsp1_valid_d ? rx_q  : rsp1_data_q;
      rsp1_err_d   = rsp1_valid_d ? err_q : rsp1_err_q;
   end

   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         state_q      <= S_IDLE;
         phase_q      <= 1'b0;
         cnt_q        <= '0;
         data_q       <= '0;
         rx_q         <= '0;
         err_q        <= 1'b0;
         grant_q      <= 2'b00;
         rr_last_q    <= 1'b1;
         ready_en_q   <= 1'b0;
         tx_en_q      <= 1'b0;
         rx_en_q      <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         raddr_q      <= '0;
         rsp0_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp0_err_q   <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_data_q  <= '0;
         rsp1_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         rx_q         <= rx_d;
         err_q        <= err_d;
         grant_q      <= grant_d;
         rr_last_q    <= rr_last_d;
         ready_en_q   <= 1'b1;
         tx_en_q      <= tx_en_d;
         rx_en_q      <= rx_en_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         raddr_q      <= raddr_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp1_err_q   <= rsp1_err_d;
      end
   end

   assign O_TX_EN    = tx_en_q;
   assign O_WADDR    = waddr_q;
   assign O_WDATA    = wdata_q;
   assign O_RX_EN    = rx_en_q;
   assign O_RADDR    = raddr_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp0_err   = rsp0_err_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_data  = rsp1_data_q;
   assign rsp1_err   = rsp1_err_q;
   assign busy       = (state_q != S_IDLE);
   assign grant      = grant_q;

endmodule
